// File: rtl/canny_pkg.sv
// -----------------------------------------------------------------------------
// canny_pkg
// Shared types and constants for the Canny edge-detection datapath.
//   dir_t        : quantized gradient direction (0/45/90/135 degrees)
//   gdq_state_t  : state encoding of the gradient-direction quantizer FSM
//   TAN22_Q_DEF  : tan(22.5 deg) * 2^8, default lower diagonal threshold
//   TAN67_Q_DEF  : tan(67.5 deg) * 2^8, default upper diagonal threshold
// -----------------------------------------------------------------------------
package canny_pkg;

   typedef enum logic [1:0] {
      DIR_0   = 2'd0,
      DIR_45  = 2'd1,
      DIR_90  = 2'd2,
      DIR_135 = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESULT = 2'd3
   } gdq_state_t;

   localparam int TAN22_Q_DEF = 106;
   localparam int TAN67_Q_DEF = 618;

endpackage

// File: rtl/grad_dir_quant.sv
// -----------------------------------------------------------------------------
// grad_dir_quant
// Gradient-direction quantizer between the Sobel stage and non-max suppression.
// Takes a signed (Gx, Gy) pair, requests |Gy|<<FRAC_BITS / |Gx| from the shared
// sequential divider, and bins the resulting tan ratio into 0/45/90/135 deg.
// Also produces the L1 magnitude |Gx|+|Gy|. One pair is in flight at a time.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   in_valid/in_ready gradient pair handshake (ready only when idle)
//   in_gx, in_gy      signed Sobel gradients, GRAD_WIDTH bits
//   out_valid/ready   result handshake; outputs held while out_ready is low
//   out_dir           quantized direction (dir_t encoding)
//   out_mag           unsigned |Gx|+|Gy|, GRAD_WIDTH+1 bits
//   div_valid_in      one-cycle divide request to the external divider
//   div_dividend      |Gy|<<FRAC_BITS, zero-extended, held until result
//   div_divisor       |Gx|, zero-extended, held until result
//   div_valid_out     divider result strobe (only honoured while waiting)
//   div_quotient      divider quotient
//   div_overflow      divider divide-by-zero flag
// -----------------------------------------------------------------------------
module grad_dir_quant
   import canny_pkg::*;
#(
   parameter int GRAD_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int DIV_WIDTH  = 32,
   parameter int TAN22_Q    = TAN22_Q_DEF,
   parameter int TAN67_Q    = TAN67_Q_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [GRAD_WIDTH-1:0]   in_gx,
   input  logic [GRAD_WIDTH-1:0]   in_gy,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [1:0]              out_dir,
   output logic [GRAD_WIDTH:0]     out_mag,
   output logic                    div_valid_in,
   output logic [DIV_WIDTH-1:0]    div_dividend,
   output logic [DIV_WIDTH-1:0]    div_divisor,
   input  logic                    div_valid_out,
   input  logic [DIV_WIDTH-1:0]    div_quotient,
   input  logic                    div_overflow
);

   localparam int MAG_W = GRAD_WIDTH + 1;
   localparam logic [DIV_WIDTH-1:0] LP_TAN22 = DIV_WIDTH'(TAN22_Q);
   localparam logic [DIV_WIDTH-1:0] LP_TAN67 = DIV_WIDTH'(TAN67_Q);

   // Absolute value in one extra bit so the most negative input is exact.
   function automatic logic [MAG_W-1:0] abs_ext(input logic [GRAD_WIDTH-1:0] v);
      logic [MAG_W-1:0] ext;
      ext = {v[GRAD_WIDTH-1], v};
      return v[GRAD_WIDTH-1] ? (~ext + MAG_W'(1)) : ext;
   endfunction

   // Bins the tan ratio. Equality with the lower threshold counts as
   // diagonal; equality with the upper threshold counts as vertical.
   // The overflow case cannot occur with a nonzero divisor; it is treated
   // as vertical so a misbehaving divider still yields a sane bin.
   function automatic dir_t classify(input logic [DIV_WIDTH-1:0] q,
                                     input logic                 ovf,
                                     input logic                 same_sign);
      dir_t d;
      if (ovf)                d = DIR_90;
      else if (q < LP_TAN22)  d = DIR_0;
      else if (q >= LP_TAN67) d = DIR_90;
      else if (same_sign)     d = DIR_45;
      else                    d = DIR_135;
      return d;
   endfunction

   logic [MAG_W-1:0]     w_abs_gx;
   logic [MAG_W-1:0]     w_abs_gy;
   logic [MAG_W-1:0]     w_mag;
   logic                 w_gx_zero;
   logic                 w_gy_zero;
   logic                 w_sign_same;
   logic [DIV_WIDTH-1:0] w_dividend;
   logic [DIV_WIDTH-1:0] w_divisor;

   assign w_abs_gx    = abs_ext(in_gx);
   assign w_abs_gy    = abs_ext(in_gy);
   // Each abs is at most 2^(GRAD_WIDTH-1), so the sum fits in MAG_W bits.
   assign w_mag       = w_abs_gx + w_abs_gy;
   assign w_gx_zero   = (in_gx == '0);
   assign w_gy_zero   = (in_gy == '0);
   assign w_sign_same = (in_gx[GRAD_WIDTH-1] == in_gy[GRAD_WIDTH-1]);
   assign w_dividend  = DIV_WIDTH'(w_abs_gy) << FRAC_BITS;
   assign w_divisor   = DIV_WIDTH'(w_abs_gx);

   gdq_state_t           r_state;
   logic                 r_in_ready;
   logic                 r_out_valid;
   dir_t                 r_dir;
   logic [MAG_W-1:0]     r_mag;
   logic                 r_sign_same;
   logic                 r_div_valid;
   logic [DIV_WIDTH-1:0] r_dividend;
   logic [DIV_WIDTH-1:0] r_divisor;

   // All handshake outputs are registered alongside the state so each one
   // is high exactly while the FSM sits in the matching state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_dir       <= DIR_0;
         r_mag       <= '0;
         r_sign_same <= 1'b0;
         r_div_valid <= 1'b0;
         r_dividend  <= '0;
         r_divisor   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_in_ready  <= 1'b0;
                  r_mag       <= w_mag;
                  r_sign_same <= w_sign_same;
                  if (w_gx_zero) begin
                     // Vertical gradient (or none): no ratio to compute.
                     r_dir       <= w_gy_zero ? DIR_0 : DIR_90;
                     r_out_valid <= 1'b1;
                     r_state     <= ST_RESULT;
                  end else begin
                     r_dividend  <= w_dividend;
                     r_divisor   <= w_divisor;
                     r_div_valid <= 1'b1;
                     r_state     <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               r_div_valid <= 1'b0;
               r_state     <= ST_WAIT;
            end
            ST_WAIT: begin
               // Operands stay put: the divider samples them after accept.
               if (div_valid_out) begin
                  r_dir       <= classify(div_quotient, div_overflow, r_sign_same);
                  r_out_valid <= 1'b1;
                  r_state     <= ST_RESULT;
               end
            end
            ST_RESULT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_div_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready     = r_in_ready;
   assign out_valid    = r_out_valid;
   assign out_dir      = r_dir;
   assign out_mag      = r_mag;
   assign div_valid_in = r_div_valid;
   assign div_dividend = r_dividend;
   assign div_divisor  = r_divisor;

endmodule
